// File: rtl/irig_pkg.sv
// irig_pkg: shared symbol/state types and CLK_HZ-derived pulse-width thresholds for the IRIG-B decoder.
package irig_pkg;
    typedef enum logic [1:0] {SYM_ZERO, SYM_ONE, SYM_MARK, SYM_INVALID} sym_t;
    typedef enum logic [1:0] {HUNT, ONE_MARK, LOCKED} state_t;
    localparam int LAST_POS = 99;
    function automatic int t_min(int clk_hz);
        return clk_hz / 10_000 * 10;
    endfunction
    function automatic int t_one(int clk_hz);
        return clk_hz / 10_000 * 35;
    endfunction
    function automatic int t_mark(int clk_hz);
        return clk_hz / 10_000 * 65;
    endfunction
    function automatic int t_max(int clk_hz);
        return clk_hz / 10_000 * 90;
    endfunction
    function automatic int t_period(int clk_hz);
        return clk_hz / 10_000 * 110;
    endfunction
    function automatic logic is_mark_pos(logic [6:0] p);
        return p == 7'd0 || p % 7'd10 == 7'd9;
    endfunction
endpackage

// File: rtl/irig_symbol_decoder.sv
// irig_symbol_decoder: synchronizes irigb, measures high width and symbol period,
// and emits a one-cycle strobe with the classified symbol.
module irig_symbol_decoder
    import irig_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000
) (
    input  logic       clk_10mhz,
    input  logic       rst,
    input  logic       irigb,
    output logic       rise,
    output logic       sym_valid,
    output logic [1:0] sym
);
    localparam int CW = $clog2(t_period(CLK_HZ) + 2);
    localparam logic [CW-1:0] H_MIN = CW'(t_min(CLK_HZ));
    localparam logic [CW-1:0] H_ONE = CW'(t_one(CLK_HZ));
    localparam logic [CW-1:0] H_MARK = CW'(t_mark(CLK_HZ));
    localparam logic [CW-1:0] H_MAX = CW'(t_max(CLK_HZ));
    localparam logic [CW-1:0] H_TO = CW'(t_max(CLK_HZ) - 1);
    localparam logic [CW-1:0] P_MAX = CW'(t_period(CLK_HZ));
    logic s1, s2, s3, fall, high_to, per_to, done;
    logic [CW-1:0] high_cnt, per_cnt;
    // A pulse that already timed out was reported as invalid; its late fall is ignored.
    assign done = fall && high_cnt < H_MAX;
    assign high_to = s3 && !rise && high_cnt == H_TO;
    assign per_to = !rise && per_cnt == P_MAX;
    always_ff @(posedge clk_10mhz or negedge rst) begin
        if (!rst) begin
            {s1, s2, s3, rise, fall, sym_valid} <= '0;
            high_cnt <= '0;
            per_cnt <= '0;
            sym <= '0;
        end else begin
            s1 <= irigb;
            s2 <= s1;
            s3 <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
            high_cnt <= rise ? CW'(1) : (s3 && high_cnt < H_MAX) ? high_cnt + 1'b1 : high_cnt;
            per_cnt <= rise ? CW'(1) : per_cnt > P_MAX ? per_cnt : per_cnt + 1'b1;
            sym_valid <= done || high_to || per_to;
            sym <= !done ? SYM_INVALID : high_cnt < H_MIN ? SYM_INVALID :
                   high_cnt < H_ONE ? SYM_ZERO : high_cnt < H_MARK ? SYM_ONE : SYM_MARK;
        end
    end
endmodule

// File: rtl/irig.sv
// irig: IRIG-B frame lock FSM and pps generator aligned to the on-time edge of position 0.
module irig
    import irig_pkg::*;
#(
    parameter int CLK_HZ    = 10_000_000,
    parameter int PPS_WIDTH = 1
) (
    input  logic clk_10mhz,
    input  logic rst,
    input  logic irigb,
    output logic pps
);
    logic [1:0] rst_sync;
    logic rst_s, rise, sym_valid, armed, sym_ok;
    logic [1:0] sym;
    logic [6:0] pos, nxt;
    logic [31:0] pps_left;
    state_t state;
    // Asynchronous assert, release retimed to the clock.
    always_ff @(posedge clk_10mhz or negedge rst) begin
        if (!rst) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_s = rst_sync[1];
    irig_symbol_decoder #(.CLK_HZ(CLK_HZ)) u_dec (
        .clk_10mhz(clk_10mhz),
        .rst(rst_s),
        .irigb(irigb),
        .rise(rise),
        .sym_valid(sym_valid),
        .sym(sym)
    );
    assign nxt = pos == 7'(LAST_POS) ? 7'd0 : pos + 7'd1;
    assign sym_ok = sym != SYM_INVALID && ((sym == SYM_MARK) == is_mark_pos(nxt));
    always_ff @(posedge clk_10mhz or negedge rst_s) begin
        if (!rst_s) begin
            state <= HUNT;
            pos <= '0;
            armed <= 1'b0;
            pps <= 1'b0;
            pps_left <= '0;
        end else begin
            if (rise && armed) begin
                pps <= 1'b1;
                pps_left <= 32'(PPS_WIDTH - 1);
                armed <= 1'b0;
            end else if (pps_left != 0) pps_left <= pps_left - 1'b1;
            else pps <= 1'b0;
            if (sym_valid)
                case (state)
                    HUNT: state <= sym == SYM_MARK ? ONE_MARK : HUNT;
                    ONE_MARK: begin
                        state <= sym == SYM_MARK ? LOCKED : HUNT;
                        pos <= '0;
                    end
                    default:
                        if (sym_ok) begin
                            pos <= nxt;
                            if (nxt == 7'(LAST_POS)) armed <= 1'b1;
                        end else begin
                            state <= HUNT;
                            pos <= '0;
                            armed <= 1'b0;
                        end
                endcase
        end
    end
endmodule

// File: tb/tb_irig.sv
// tb_irig: directed checks of symbol classification, frame lock, pps timing and loss of lock.
module tb_irig;
    import irig_pkg::*;
    logic clk_10mhz = 0, rst = 0, irigb = 0, pps;
    int total = 0, bad = 0, pps_total = 0, nsym = 0;
    logic [1:0] last_sym = '0;
    irig #(.CLK_HZ(10_000), .PPS_WIDTH(1)) dut (
        .clk_10mhz(clk_10mhz),
        .rst(rst),
        .irigb(irigb),
        .pps(pps)
    );
    always #5 clk_10mhz = ~clk_10mhz;
    always @(posedge clk_10mhz) begin
        #1;
        if (pps) pps_total++;
        if (dut.sym_valid) begin
            nsym++;
            last_sym = dut.sym;
        end
    end
    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout want completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
    task automatic send_sym(input int h, input int p);
        irigb = 1;
        repeat (h) @(negedge clk_10mhz);
        irigb = 0;
        repeat (p - h) @(negedge clk_10mhz);
    endtask
    task automatic send_pos(input int p);
        send_sym((p == 0 || p % 10 == 9) ? 80 : (p % 2 == 1 ? 50 : 20), 100);
    endtask
    task automatic idle(input int n);
        irigb = 0;
        repeat (n) @(negedge clk_10mhz);
    endtask
    task automatic test_reset;
        rst = 0;
        repeat (3) @(negedge clk_10mhz);
        total++; if (pps !== 1'b0) begin bad++; $display("FAIL reset_pps got=%0d want=0", pps); end
        total++; if (dut.state !== HUNT) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state, HUNT); end
        total++; if (dut.pos !== 7'd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", dut.pos); end
        rst = 1;
        repeat (5) @(negedge clk_10mhz);
    endtask
    task automatic test_boundaries;
        int w[8] = '{34, 35, 64, 65, 9, 10, 89, 90};
        logic [1:0] e[8] = '{SYM_ZERO, SYM_ONE, SYM_ONE, SYM_MARK, SYM_INVALID, SYM_ZERO, SYM_MARK, SYM_INVALID};
        for (int i = 0; i < 8; i++) begin
            int n0 = nsym;
            send_sym(w[i], 100);
            total++; if (nsym !== n0 + 1) begin bad++; $display("FAIL width%0d_count got=%0d want=%0d", w[i], nsym - n0, 1); end
            total++; if (last_sym !== e[i]) begin bad++; $display("FAIL width%0d_class got=%0d want=%0d", w[i], last_sym, e[i]); end
        end
        idle(200);
    endtask
    task automatic test_hunt_seq;
        int p0 = pps_total;
        send_sym(20, 100);
        send_sym(80, 100);
        total++; if (dut.state !== ONE_MARK) begin bad++; $display("FAIL hunt_after_mark got=%0d want=%0d", dut.state, ONE_MARK); end
        send_sym(50, 100);
        total++; if (dut.state !== HUNT) begin bad++; $display("FAIL hunt_after_d1 got=%0d want=%0d", dut.state, HUNT); end
        send_sym(20, 100);
        total++; if (pps_total !== p0) begin bad++; $display("FAIL hunt_pps got=%0d want=%0d", pps_total - p0, 0); end
        idle(200);
    endtask
    task automatic test_frame;
        int p0 = pps_total;
        send_pos(0);
        send_pos(0);
        total++; if (dut.state !== LOCKED || dut.pos !== 7'd0) begin bad++; $display("FAIL frame_lock got=%0d/%0d want=%0d/0", dut.state, dut.pos, LOCKED); end
        for (int p = 1; p < 100; p++) send_pos(p);
        total++; if (pps_total !== p0) begin bad++; $display("FAIL frame_early_pps got=%0d want=%0d", pps_total - p0, 0); end
        total++; if (dut.pos !== 7'd99) begin bad++; $display("FAIL frame_pos99 got=%0d want=99", dut.pos); end
        irigb = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_10mhz);
            total++; if (pps !== (k == 4)) begin bad++; $display("FAIL pps_cycle%0d got=%0d want=%0d", k, pps, k == 4); end
        end
        repeat (74) @(negedge clk_10mhz);
        idle(20);
        total++; if (pps_total !== p0 + 1) begin bad++; $display("FAIL frame_pps_count got=%0d want=1", pps_total - p0); end
        total++; if (dut.state !== LOCKED || dut.pos !== 7'd0) begin bad++; $display("FAIL frame_relock got=%0d/%0d want=%0d/0", dut.state, dut.pos, LOCKED); end
    endtask
    task automatic test_bad_data;
        int p0 = pps_total;
        for (int p = 1; p < 29; p++) send_pos(p);
        send_sym(50, 100);
        total++; if (dut.state !== HUNT) begin bad++; $display("FAIL bad29_state got=%0d want=%0d", dut.state, HUNT); end
        for (int p = 30; p < 100; p++) send_pos(p);
        send_pos(0);
        total++; if (pps_total !== p0) begin bad++; $display("FAIL bad29_pps got=%0d want=0", pps_total - p0); end
        total++; if (dut.state !== LOCKED || dut.pos !== 7'd0) begin bad++; $display("FAIL bad29_reacq got=%0d/%0d want=%0d/0", dut.state, dut.pos, LOCKED); end
    endtask
    task automatic test_low_timeout;
        int p0;
        for (int p = 1; p < 100; p++) send_pos(p);
        total++; if (dut.armed !== 1'b1) begin bad++; $display("FAIL low_armed got=%0d want=1", dut.armed); end
        p0 = pps_total;
        idle(10);
        total++; if (dut.state !== LOCKED) begin bad++; $display("FAIL low_before got=%0d want=%0d", dut.state, LOCKED); end
        idle(10);
        total++; if (dut.state !== HUNT) begin bad++; $display("FAIL low_after got=%0d want=%0d", dut.state, HUNT); end
        total++; if (dut.armed !== 1'b0) begin bad++; $display("FAIL low_disarm got=%0d want=0", dut.armed); end
        idle(180);
        send_pos(0);
        total++; if (pps_total !== p0) begin bad++; $display("FAIL low_pps got=%0d want=0", pps_total - p0); end
    endtask
    task automatic test_high_timeout;
        send_pos(0);
        total++; if (dut.state !== LOCKED) begin bad++; $display("FAIL high_lock got=%0d want=%0d", dut.state, LOCKED); end
        irigb = 1;
        repeat (90) @(negedge clk_10mhz);
        total++; if (dut.state !== LOCKED) begin bad++; $display("FAIL high_before got=%0d want=%0d", dut.state, LOCKED); end
        repeat (10) @(negedge clk_10mhz);
        total++; if (dut.state !== HUNT) begin bad++; $display("FAIL high_after got=%0d want=%0d", dut.state, HUNT); end
        total++; if (last_sym !== SYM_INVALID) begin bad++; $display("FAIL high_sym got=%0d want=%0d", last_sym, SYM_INVALID); end
        idle(200);
    endtask
    task automatic test_reset_midframe;
        send_pos(0);
        send_pos(0);
        for (int p = 1; p < 5; p++) send_pos(p);
        irigb = 1;
        repeat (10) @(negedge clk_10mhz);
        #2 rst = 0;
        #1;
        total++; if (dut.state !== HUNT || dut.pos !== 7'd0) begin bad++; $display("FAIL midrst_state got=%0d/%0d want=%0d/0", dut.state, dut.pos, HUNT); end
        total++; if (pps !== 1'b0) begin bad++; $display("FAIL midrst_pps got=%0d want=0", pps); end
        irigb = 0;
        repeat (3) @(negedge clk_10mhz);
        rst = 1;
        repeat (5) @(negedge clk_10mhz);
        send_pos(0);
        total++; if (dut.state !== ONE_MARK) begin bad++; $display("FAIL midrst_one got=%0d want=%0d", dut.state, ONE_MARK); end
        send_pos(0);
        total++; if (dut.state !== LOCKED) begin bad++; $display("FAIL midrst_two got=%0d want=%0d", dut.state, LOCKED); end
    endtask
    initial begin
        test_reset;
        test_boundaries;
        test_hunt_seq;
        test_frame;
        test_bad_data;
        test_low_timeout;
        test_high_timeout;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
